// File: rtl/pool2_mul_pkg.sv
// Pool2 multiplier shared types and helpers.
// Used by pool2_mul_pipe and pool2_mul_narrow.
package pool2_mul_pkg;

  localparam int MUL_MAX_STAGE = 4;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } mul_mode_t;

  function automatic int prod_width(input int a, input int b);
    return a + b + 2;
  endfunction

endpackage

// File: rtl/pool2_mul_narrow.sv
// Product-to-result narrowing: wrap by default,
// clamp to result range when MUL_SAT_EN is defined.
module pool2_mul_narrow
  import pool2_mul_pkg::*;
#(
  parameter int P_WIDTH    = 13,
  parameter int dout_WIDTH = 10
) (
  input  logic [P_WIDTH-1:0]    product,
  input  logic                  is_signed,
  output logic [dout_WIDTH-1:0] result
);

`ifdef MUL_SAT_EN
  if (dout_WIDTH >= P_WIDTH) begin : g_fit
    logic unused_sign;
    assign unused_sign = is_signed;
    assign result = product[dout_WIDTH-1:0];
  end else begin : g_sat
    localparam int H = P_WIDTH - dout_WIDTH;
    logic [H-1:0] hi;
    logic [H:0]   sbits;
    logic         sign;
    assign hi    = product[P_WIDTH-1:dout_WIDTH];
    assign sbits = {hi, product[dout_WIDTH-1]};
    assign sign  = product[P_WIDTH-1];
    // clamp when the dropped bits carry magnitude
    always_comb begin
      result = product[dout_WIDTH-1:0];
      if (is_signed) begin
        if (!(&sbits) && (|sbits)) begin
          result = sign ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                        : {1'b0, {(dout_WIDTH-1){1'b1}}};
        end
      end else if (|hi) begin
        result = '1;
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{is_signed, product};
  assign result = product[dout_WIDTH-1:0];
`endif

endmodule

// File: rtl/pool2_mul_pipe.sv
// Pipelined mixed-sign multiplier, 1..4 stages, valid/ready.
// Optional MUL_SAT_EN: saturating narrowing instead of wrap.
module pool2_mul_pipe
  import pool2_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 4,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int P = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int R = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam int unused_id = ID;

  if (NUM_STAGE < 1 || NUM_STAGE > MUL_MAX_STAGE) begin : g_bad_stage
    $error("pool2_mul_pipe: NUM_STAGE must be 1..4");
  end
  if (dout_WIDTH > P) begin : g_bad_width
    $error("pool2_mul_pipe: dout_WIDTH exceeds product width");
  end

  logic                  ce;
  mul_mode_t             mode_in;
  logic [din0_WIDTH-1:0] a_src;
  logic [din1_WIDTH-1:0] b_src;
  mul_mode_t             mode_src;
  logic                  v_src;
  logic [din0_WIDTH:0]   a_ext;
  logic [din1_WIDTH:0]   b_ext;
  logic signed [P-1:0]   a_wide;
  logic signed [P-1:0]   b_wide;
  logic signed [P-1:0]   product;
  logic [dout_WIDTH-1:0] narrowed;

  logic [R-1:0][dout_WIDTH-1:0] res_q;
  logic [R-1:0]                 vld_q;

  assign ce       = out_ready | ~out_valid;
  assign in_ready = ce;
  assign mode_in  = {din0_signed, din1_signed};

  if (NUM_STAGE == 1) begin : g_comb_in
    assign a_src    = din0;
    assign b_src    = din1;
    assign mode_src = mode_in;
    assign v_src    = in_valid;
  end else begin : g_reg_in
    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;
    mul_mode_t             mode_q;
    logic                  v_q;
    // stage 1: capture operands and signedness
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        a_q    <= '0;
        b_q    <= '0;
        mode_q <= '0;
        v_q    <= 1'b0;
      end else if (ce) begin
        a_q    <= din0;
        b_q    <= din1;
        mode_q <= mode_in;
        v_q    <= in_valid;
      end
    end
    assign a_src    = a_q;
    assign b_src    = b_q;
    assign mode_src = mode_q;
    assign v_src    = v_q;
  end

  assign a_ext = {mode_src.a_signed & a_src[din0_WIDTH-1], a_src};
  assign b_ext = {mode_src.b_signed & b_src[din1_WIDTH-1], b_src};

  assign a_wide = {{(P-din0_WIDTH-1){a_ext[din0_WIDTH]}}, a_ext};
  assign b_wide = {{(P-din1_WIDTH-1){b_ext[din1_WIDTH]}}, b_ext};

  assign product = a_wide * b_wide;

  pool2_mul_narrow #(
    .P_WIDTH    (P),
    .dout_WIDTH (dout_WIDTH)
  ) u_narrow (
    .product   (product),
    .is_signed (mode_src.a_signed | mode_src.b_signed),
    .result    (narrowed)
  );

  // result stages: shift narrowed product and valid together
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_q <= '0;
      vld_q <= '0;
    end else if (ce) begin
      res_q[0] <= narrowed;
      vld_q[0] <= v_src;
      for (int k = 1; k < R; k++) begin
        res_q[k] <= res_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign dout      = res_q[R-1];
  assign out_valid = vld_q[R-1];

endmodule

// File: tb/tb_pool2_mul_pipe.sv
// Directed bench for pool2_mul_pipe: vector table,
// back-pressure, reset mid-flight, 1..4 stage sweep.
`timescale 1ns/1ps
module tb_pool2_mul_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       sa = 1'b0;
  logic       sb = 1'b0;
  logic [3:0] din0 = '0;
  logic [6:0] din1 = '0;

  wire [3:0] ov;
  wire [3:0] ir;
  wire [9:0] dv [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pool2_mul_pipe #(
      .ID         (g),
      .NUM_STAGE  (g + 1),
      .din0_WIDTH (4),
      .din1_WIDTH (7),
      .dout_WIDTH (10)
    ) u_dut (
      .ap_clk      (clk),
      .ap_rst_n    (rst_n),
      .in_valid    (in_valid),
      .in_ready    (ir[g]),
      .din0        (din0),
      .din1        (din1),
      .din0_signed (sa),
      .din1_signed (sb),
      .out_valid   (ov[g]),
      .out_ready   (out_ready),
      .dout        (dv[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [6:0] b;
    logic       sa;
    logic       sb;
    int         exp_wrap;
    int         exp_sat;
  } vec_t;

  vec_t tbl [10];

  initial begin : main
    int idx;
    int hold;
    bit started;
    int got [$];
    int bp_a [3];
    int bp_b [3];
    int bp_e [3];
    int stale;
    int e;

    tbl[0] = '{4'd15, 7'd127, 1'b0, 1'b0, 881, 1023};
    tbl[1] = '{4'h8, 7'h40, 1'b1, 1'b1, 512, 511};
    tbl[2] = '{4'hF, 7'd100, 1'b1, 1'b0, 924, 924};
    tbl[3] = '{4'd3, 7'd5, 1'b0, 1'b0, 15, 15};
    tbl[4] = '{4'd0, 7'd127, 1'b1, 1'b1, 0, 0};
    tbl[5] = '{4'd7, 7'h7F, 1'b1, 1'b1, 1017, 1017};
    tbl[6] = '{4'd15, 7'h40, 1'b0, 1'b1, 64, 512};
    tbl[7] = '{4'h8, 7'd127, 1'b1, 1'b0, 8, 512};
    tbl[8] = '{4'd10, 7'd50, 1'b0, 1'b0, 500, 500};
    tbl[9] = '{4'h8, 7'd63, 1'b1, 1'b1, 520, 520};

    bp_a = '{3, 2, 1};
    bp_b = '{5, 6, 7};
    bp_e = '{15, 12, 7};

    // reset state
    #12;
    chk("rst_valid", 32'(ov[1]), 0);
    chk("rst_dout", 32'(dv[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ir[1]), 1);

    // vector table, 2-stage instance
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din0 = tbl[i].a;
      din1 = tbl[i].b;
      sa = tbl[i].sa;
      sb = tbl[i].sb;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("vec_early", 32'(ov[1]), 0);
      @(negedge clk);
      #1;
`ifdef MUL_SAT_EN
      e = tbl[i].exp_sat;
`else
      e = tbl[i].exp_wrap;
`endif
      chk("vec_valid", 32'(ov[1]), 1);
      chk($sformatf("vec%0d_dout", i), 32'(dv[1]), e);
    end
    @(negedge clk);
    @(negedge clk);

    // back-pressure: hold 3 cycles after first result
    idx = 0;
    hold = 0;
    started = 1'b0;
    sa = 1'b0;
    sb = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = (idx < 3);
      din0 = (idx < 3) ? 4'(bp_a[idx]) : 4'd0;
      din1 = (idx < 3) ? 7'(bp_b[idx]) : 7'd0;
      if (ov[1] && !started) begin
        started = 1'b1;
        hold = 3;
      end
      out_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        chk("bp_hold_dout", 32'(dv[1]), 15);
        chk("bp_hold_valid", 32'(ov[1]), 1);
        chk("bp_in_ready", 32'(ir[1]), 0);
        hold--;
      end
      if (ov[1] && out_ready) got.push_back(int'(dv[1]));
      if (in_valid && ir[1]) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("bp_order", (k < got.size()) ? got[k] : -1, bp_e[k]);
    end

    // reset with two results in flight
    @(negedge clk);
    din0 = 4'd3;
    din1 = 7'd5;
    in_valid = 1'b1;
    @(negedge clk);
    din0 = 4'd2;
    din1 = 7'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(ov[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov[1]), 0);
    chk("mid_rst_dout", 32'(dv[1]), 0);
    chk("mid_rst_valid4", 32'(ov[3]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (ov != 4'b0) stale++;
    end
    chk("no_stale", stale, 0);

    // latency sweep across 1..4 stages
    @(negedge clk);
    din0 = 4'd1;
    din1 = 7'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      din0 = 4'(c + 1);
      din1 = 7'd2;
      #1;
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("sweep%0d_valid", n + 1),
            32'(ov[n]), 32'(c >= n + 1));
        if (c >= n + 1) begin
          chk($sformatf("sweep%0d_dout", n + 1),
              32'(dv[n]), (c - n) * 2);
        end
      end
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pool2_mul_pipe.md
Name: pool2_mul_pipe

Overview:
Parametrised, pipelined integer multiplier for the Pool2 datapath. It replaces fixed-width combinational unsigned multipliers with one configurable block that has:
- selectable signedness per operand, sent with each transaction;
- 1..4 register stages;
- valid/ready flow control with stall.
It sits between the Pool2 address/scale logic and its consumers. It is sized so one instance covers all index and scale products.

Parameters:
ID, 1, instance tag; no functional effect.
NUM_STAGE, 2, pipeline depth in cycles; legal range 1..4.
din0_WIDTH, 4, width of operand A.
din1_WIDTH, 7, width of operand B.
dout_WIDTH, 10, result width; may be narrower than din0_WIDTH+din1_WIDTH+1.

Ports:
ap_clk  in  1  clock, rising edge.
ap_rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  operands valid this cycle.
in_ready  out  1  block accepts operands this cycle.
din0  in  din0_WIDTH  operand A.
din1  in  din1_WIDTH  operand B.
din0_signed  in  1  1 = din0 is two's complement; 0 = unsigned.
din1_signed  in  1  1 = din1 is two's complement; 0 = unsigned.
out_valid  out  1  dout holds a result.
out_ready  in  1  consumer accepts dout.
dout  out  dout_WIDTH  product.

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst_n is asynchronous, active-low.
- While ap_rst_n=0, all valid bits, data registers and dout are 0; in_ready reads 1 once reset is released.
- Extension: each operand is extended by 1 bit, using its sign bit if its signed flag is set, else 0.
- Product: full signed product of width P = din0_WIDTH+din1_WIDTH+2. This is exact for every mode.
- Signed result: the result is signed if din0_signed or din1_signed is set, else unsigned. This signedness travels with the data through the pipeline.
- Output narrowing (default): dout = P[dout_WIDTH-1:0], i.e. wrap.
- Pipeline, NUM_STAGE=1: multiply is combinational from the inputs; the narrowed result is registered once.
- Pipeline, NUM_STAGE>=2: stage 1 registers operands and flags; the multiply sits between stage 1 and stage 2; stages 2..N register the narrowed product.
- Global enable: ce = out_ready | ~out_valid. in_ready = ce.
- Registers: all stage registers and their per-stage valid bits advance only when ce=1.
- Bubbles: bubbles are not compressed; an invalid stage still shifts.
- Acceptance: a transaction is accepted when in_valid & in_ready.
- Latency: exactly NUM_STAGE cycles from accept to out_valid when there is no stall.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0:
  - the whole pipe holds;
  - dout and out_valid are stable;
  - in_ready=0.
- Accept and drain in the same cycle: allowed when out_ready=1 (ce=1).
- in_valid=0 while ce=1: a bubble is inserted and valid propagates as 0.
- Reset mid-operation: all in-flight results are discarded; out_valid drops asynchronously.
- Parameter check: NUM_STAGE outside 1..4 is an elaboration error, raised by a generate-time check.

Optional Feature:
MUL_SAT_EN
- Defined:
  - the narrowing step saturates instead of wrapping;
  - signed result: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1];
  - unsigned result: clamp to [0, 2^dout_WIDTH-1];
  - no latency change; saturation sits in the same combinational stage as the narrowing.
- Undefined: pure truncation, as above. No sat logic is instantiated.

Decomposition:
- Package pool2_mul_pkg:
  - localparam MUL_MAX_STAGE=4;
  - function prod_width(a,b) returning a+b+2;
  - typedef mul_mode_t (struct: a_signed, b_signed).
- Sub-module pool2_mul_narrow: combinational P-to-dout_WIDTH narrowing.
  - Parameters: P_WIDTH, dout_WIDTH.
  - Inputs: product, is_signed.
  - Contains the MUL_SAT_EN branch.

Test Plan:
- Unsigned wrap, defaults: din0=15, din1=127, both flags 0 -> dout=881 after 2 cycles. With MUL_SAT_EN: 1023.
- Signed: din0=4'h8 (-8), din1=7'h40 (-64), both flags 1 -> product 512; dout=10'h200 wrap. With MUL_SAT_EN: 511 (10'h1FF).
- Mixed: din0=4'hF (signed, -1), din1=100 (unsigned) -> dout=924 (-100) in both builds.
- Back-pressure:
  - stimulus: stream 3*5, 2*6, 1*7 back-to-back; hold out_ready=0 for 3 cycles after the first out_valid;
  - required: dout holds 15 and in_ready=0 during the hold; then 15, 12, 7 in order, none lost or duplicated.
- Reset mid-flight: assert ap_rst_n=0 with 2 results in flight -> out_valid=0 and dout=0 immediately; after release, no stale result appears.
- Latency sweep: NUM_STAGE=1..4 with continuous in_valid and out_ready=1 -> first out_valid at cycle N, then 1 result/cycle.
